logic_unit_arbiter: RTL and testbench
=====================================

# logic_unit_arbiter

Two-requester round-robin arbiter and sequencer for the shared 8-bit logic unit (AND/OR/XOR/NOT). It accepts operations from two clients over valid/ready handshakes and drives the logic unit's `a`, `b` and `select` from registered operands. It captures the combinational result and returns it with the requester ID over a valid/ready response channel with backpressure.

## Interface
- `WIDTH`, 8: operand and result width. It must match the logic unit datapath; only 8 is supported.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has an operation pending.
- `req0_ready`  out  1  requester 0 operation accepted this cycle.
- `req0_a`, `req0_b`  in  8 each  requester 0 operands.
- `req0_op`  in  2  requester 0 opcode.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_op`: same as requester 0, for requester 1.
- `lu_a`, `lu_b`  out  8 each  registered operands to the logic unit.
- `lu_select`  out  2  registered opcode to the logic unit.
- `lu_result`  in  8  combinational result from the logic unit.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_id`  out  1  index of the requester that issued the operation.
- `rsp_data`  out  8  captured result.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- **Opcodes:**
  - 00: AND.
  - 01: OR.
  - 10: XOR.
  - 11: NOT `a`; `b` is ignored but still forwarded.
- **FSM states:** IDLE, ISSUE, RESP. Reset state is IDLE.
- **Arbitration window:** open in IDLE, and in RESP when `rsp_ready`=1. Closed in ISSUE, and in RESP with `rsp_ready`=0; while closed, both `reqN_ready` are 0.
- **Winner selection:**
  - If only one `reqN_valid` is high, that requester wins.
  - If both are high, the requester indicated by the priority pointer wins.
  - The pointer resets to 0. After each grant it points to the non-granted requester.
- **Ready:**
  - `reqN_ready` is combinational from both valids, the pointer, state and `rsp_ready`.
  - At most one `reqN_ready` is high per cycle.
  - A handshake is `reqN_valid & reqN_ready`.
- **On handshake:**
  - Load `lu_a`/`lu_b`/`lu_select` from the winner's inputs.
  - Load the ID register with the winner's index.
  - Update the pointer.
  - Next state is ISSUE.
- **ISSUE:**
  - Capture `lu_result` into `rsp_data`.
  - Copy the ID register to `rsp_id`.
  - Set `rsp_valid`=1. Next state is RESP.
- **RESP:**
  - `rsp_valid`, `rsp_data` and `rsp_id` are held stable until `rsp_valid & rsp_ready`.
  - On that transfer with a new handshake in the same cycle: next state is ISSUE and `rsp_valid` falls.
  - On that transfer with no handshake: next state is IDLE and `rsp_valid` falls.
  - With `rsp_ready`=0: remain in RESP.
- **Requester obligation:** hold `reqN_valid` and operands stable until the handshake; the block never drops a valid request.
- `lu_a`, `lu_b` and `lu_select` hold their last values between operations.

## Timing
- **Reset values:**
  - 0: `reqN_ready`, `lu_a`, `lu_b`, `lu_select`, `rsp_valid`, `rsp_id`, `rsp_data`, `busy`.
  - Priority pointer 0.
- **Reset mid-operation:** asynchronous; all outputs go to their reset values immediately. Any in-flight operation or unacknowledged response is discarded.
- **Latency:** handshake in cycle N → ISSUE in cycle N+1 → `rsp_valid`=1 in cycle N+2.
- **Throughput:** with `rsp_ready` held at 1 and requests always pending, one operation per 2 cycles (RESP↔ISSUE alternation).
- **Simultaneous events:**
  - A new handshake in RESP occurs only in the cycle the current response transfers; the response is never overwritten before transfer.
  - A requester dropping valid in the same cycle the pointer favours it: the other requester wins if valid.
- **No combinational path** from `lu_result` to any output. `reqN_ready` depends combinationally on `rsp_ready`.

## Test plan
- **Reset and single AND:** reset → all outputs 0. Then req0 valid with a=0xC3, b=0x5A, op=00 → `req0_ready`=1 in cycle N. `lu_select`=00 in N+1. In N+2: `rsp_valid`=1, `rsp_data`=0x42, `rsp_id`=0.
- **All opcodes from req1:** a=0xC3, b=0x5A with op=01/10/11 → `rsp_data` = 0xDB / 0x99 / 0x3C, `rsp_id`=1 each time.
- **Contention:** both valid continuously, `rsp_ready`=1 → grants alternate 0,1,0,1. Responses arrive every 2 cycles with matching IDs and data.
- **Backpressure:** `rsp_ready`=0 for 5 cycles with both requests pending → `rsp_valid` and `rsp_data` stable and both readies 0. Raise `rsp_ready` → the pending response transfers and the next grant occurs in the same cycle.
- **Reset mid-RESP:** assert `rst` while `rsp_valid`=1 → `rsp_valid`=0 immediately. After release, state is IDLE and the pointer favours req0 under contention.
- **NOT ignores b:** a=0x0F, b=0xFF, op=11 → `rsp_data`=0xF0.

Source files
------------

// File: rtl/logic_unit_arbiter.sv
// Two-requester round-robin arbiter and sequencer for the shared 8-bit logic
// unit (AND/OR/XOR/NOT). Operands are registered toward the logic unit, the
// combinational result is captured one cycle later and returned with the
// requester id over a backpressured response channel.
//
// Handshake rule for every channel in this block: a transfer happens on a
// rising clock edge where valid and ready are both high; a producer holds
// valid and payload stable until that transfer, and ready may depend
// combinationally on valid.
module logic_unit_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,

  output logic [WIDTH-1:0] lu_a,
  output logic [WIDTH-1:0] lu_b,
  output logic [1:0]       lu_select,
  input  logic [WIDTH-1:0] lu_result,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,

  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  // Round-robin pointer: requester favoured when both are valid.
  logic ptr_q;
  // Index of the requester whose operation is currently in the logic unit.
  logic id_q;

  logic window;
  logic grant0;
  logic grant1;
  logic handshake;
  logic winner;

  // Arbitration window: open in IDLE, and in RESP only in the cycle the
  // pending response transfers, so a response is never overwritten.
  always_comb begin
    window = 1'b0;
    if (!rst) begin
      if (state_q == IDLE)
        window = 1'b1;
      else if (state_q == RESP && rsp_ready)
        window = 1'b1;
    end
  end

  // Winner selection: a lone valid wins, a tie goes to the pointer.
  always_comb begin
    grant0 = window & req0_valid & (~req1_valid | ~ptr_q);
    grant1 = window & req1_valid & (~req0_valid |  ptr_q);
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign handshake  = grant0 | grant1;
  assign winner     = grant1;
  assign busy       = (state_q != IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (handshake)
          state_d = ISSUE;
      end
      ISSUE: begin
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready)
          state_d = handshake ? ISSUE : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operand registers, id register and pointer update on each accepted op;
  // the logic unit inputs hold their last values between operations.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lu_a      <= '0;
      lu_b      <= '0;
      lu_select <= 2'b00;
      id_q      <= 1'b0;
      ptr_q     <= 1'b0;
    end else if (handshake) begin
      lu_a      <= winner ? req1_a  : req0_a;
      lu_b      <= winner ? req1_b  : req0_b;
      lu_select <= winner ? req1_op : req0_op;
      id_q      <= winner;
      ptr_q     <= ~winner;
    end
  end

  // Response channel: capture the logic unit result in ISSUE, hold it in
  // RESP until the consumer takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
    end else begin
      if (state_q == ISSUE) begin
        rsp_valid <= 1'b1;
        rsp_id    <= id_q;
        rsp_data  <= lu_result;
      end else if (state_q == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  // Only one requester may be granted per cycle.
  a_one_ready: assert property (@(posedge clk) disable iff (rst)
    !(req0_ready && req1_ready));

  // A stalled response stays valid and stable.
  a_rsp_hold: assert property (@(posedge clk) disable iff (rst)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_data) && $stable(rsp_id)));

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter with a behavioural logic unit, a
// scoreboard queue filled on request handshakes and drained by a response
// monitor.
module tb_logic_unit_arbiter;

  logic       clk;
  logic       rst;
  logic       req0_valid, req0_ready;
  logic [7:0] req0_a, req0_b;
  logic [1:0] req0_op;
  logic       req1_valid, req1_ready;
  logic [7:0] req1_a, req1_b;
  logic [1:0] req1_op;
  logic [7:0] lu_a, lu_b;
  logic [1:0] lu_select;
  logic [7:0] lu_result;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [7:0] rsp_data;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [8:0] exp_q[$];
  int         grant_log[$];
  int         rsp_cyc_log[$];
  logic [7:0] pend_exp0, pend_exp1;

  logic_unit_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .lu_a(lu_a), .lu_b(lu_b), .lu_select(lu_select), .lu_result(lu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .busy(busy)
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural logic unit.
  always_comb begin
    lu_result = 8'h00;
    case (lu_select)
      2'b00: lu_result = lu_a & lu_b;
      2'b01: lu_result = lu_a | lu_b;
      2'b10: lu_result = lu_a ^ lu_b;
      default: lu_result = ~lu_a;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: records grants into the scoreboard and checks every response.
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid && rsp_ready) begin
        rsp_cyc_log.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          check("rsp_id", {31'd0, rsp_id}, {31'd0, e[8]});
          check("rsp_data", {24'd0, rsp_data}, {24'd0, e[7:0]});
        end
      end
      if (req0_valid && req0_ready) begin
        exp_q.push_back({1'b0, pend_exp0});
        grant_log.push_back(0);
      end
      if (req1_valid && req1_ready) begin
        exp_q.push_back({1'b1, pend_exp1});
        grant_log.push_back(1);
      end
    end
  end

  // Driver: present one operation and hold it until accepted.
  task automatic send(input int id, input logic [7:0] a, input logic [7:0] b,
                      input logic [1:0] op, input logic [7:0] exp);
    int n;
    if (id == 0) begin
      req0_a = a; req0_b = b; req0_op = op; pend_exp0 = exp; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_b = b; req1_op = op; pend_exp1 = exp; req1_valid = 1'b1;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!((id == 0) ? req0_ready : req1_ready) && n < 60);
    if (n >= 60) check("grant_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    if (id == 0) req0_valid = 1'b0;
    else         req1_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rsp_valid) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", {31'd0, (n >= 60)}, 32'd0);
  endtask

  task automatic wait_rsp_valid();
    int n;
    n = 0;
    while (!rsp_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("rsp_valid_timeout", {31'd0, (n >= 30)}, 32'd0);
  endtask

  task automatic check_log_alternates(input string name, input int first, input int count);
    check({name, "_grants"}, grant_log.size(), count);
    for (int i = 0; i < grant_log.size() && i < count; i++)
      check({name, "_grant_id"}, grant_log[i], (first + i) % 2);
  endtask

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] held;
    rst = 1'b1;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0;
    rsp_ready = 1'b1;
    pend_exp0 = 0; pend_exp1 = 0;
    repeat (3) @(negedge clk);

    // Reset values.
    check("rst_req0_ready", {31'd0, req0_ready}, 0);
    check("rst_req1_ready", {31'd0, req1_ready}, 0);
    check("rst_lu", {14'd0, lu_a, lu_b, lu_select}, 0);
    check("rst_rsp", {22'd0, rsp_valid, rsp_id, rsp_data}, 0);
    check("rst_busy", {31'd0, busy}, 0);

    @(posedge clk); #1 rst = 1'b0;

    // Single AND with cycle-accurate latency.
    @(posedge clk); #1;
    req0_a = 8'hC3; req0_b = 8'h5A; req0_op = 2'b00; pend_exp0 = 8'h42; req0_valid = 1'b1;
    @(negedge clk);
    check("and_ready_N", {31'd0, req0_ready}, 1);
    check("and_req1_ready_N", {31'd0, req1_ready}, 0);
    @(posedge clk); #1 req0_valid = 1'b0;
    @(negedge clk);
    check("and_lu_select_N1", {30'd0, lu_select}, 0);
    check("and_lu_a_N1", {24'd0, lu_a}, 32'hC3);
    check("and_lu_b_N1", {24'd0, lu_b}, 32'h5A);
    check("and_rsp_valid_N1", {31'd0, rsp_valid}, 0);
    check("and_busy_N1", {31'd0, busy}, 1);
    @(negedge clk);
    check("and_rsp_valid_N2", {31'd0, rsp_valid}, 1);
    check("and_rsp_data_N2", {24'd0, rsp_data}, 32'h42);
    check("and_rsp_id_N2", {31'd0, rsp_id}, 0);
    drain();

    // NOT ignores b.
    @(posedge clk); #1;
    send(0, 8'h0F, 8'hFF, 2'b11, 8'hF0);
    drain();

    // Remaining opcodes from requester 1.
    send(1, 8'hC3, 8'h5A, 2'b01, 8'hDB);
    send(1, 8'hC3, 8'h5A, 2'b10, 8'h99);
    send(1, 8'hC3, 8'h5A, 2'b11, 8'h3C);
    drain();
    check("idle_after_ops", {31'd0, busy}, 0);

    // Contention: both valid, grants alternate, one response every 2 cycles.
    grant_log.delete();
    rsp_cyc_log.delete();
    @(posedge clk); #1;
    fork
      begin
        send(0, 8'h12, 8'h34, 2'b00, 8'h10);
        send(0, 8'hF0, 8'h0F, 2'b01, 8'hFF);
      end
      begin
        send(1, 8'hAA, 8'h55, 2'b10, 8'hFF);
        send(1, 8'h81, 8'h00, 2'b11, 8'h7E);
      end
    join
    drain();
    check_log_alternates("contention", 0, 4);
    check("contention_rsps", rsp_cyc_log.size(), 4);
    for (int i = 1; i < rsp_cyc_log.size(); i++)
      check("contention_rsp_spacing", rsp_cyc_log[i] - rsp_cyc_log[i-1], 2);

    // Backpressure: response held, readies closed, release grants same cycle.
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    fork
      send(0, 8'h3C, 8'h0F, 2'b00, 8'h0C);
      send(1, 8'h3C, 8'h0F, 2'b10, 8'h33);
    join_none
    wait_rsp_valid();
    held = rsp_data;
    check("bp_rsp_data", {24'd0, rsp_data}, 32'h0C);
    check("bp_rsp_id", {31'd0, rsp_id}, 0);
    repeat (5) begin
      @(negedge clk);
      check("bp_rsp_valid_hold", {31'd0, rsp_valid}, 1);
      check("bp_rsp_data_hold", {24'd0, rsp_data}, {24'd0, held});
      check("bp_readies_closed", {30'd0, req0_ready, req1_ready}, 0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_transfer", {31'd0, rsp_valid}, 1);
    check("bp_release_grant1", {31'd0, req1_ready}, 1);
    wait fork;
    drain();

    // Reset mid-RESP: leave pointer at 1, then reset while a response is held.
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    fork
      send(0, 8'h55, 8'hAA, 2'b01, 8'hFF);
    join_none
    wait_rsp_valid();
    wait fork;
    #2 rst = 1'b1;
    #1;
    check("midrst_rsp_valid", {31'd0, rsp_valid}, 0);
    check("midrst_busy", {31'd0, busy}, 0);
    check("midrst_rsp_data", {24'd0, rsp_data}, 0);
    check("midrst_lu", {14'd0, lu_a, lu_b, lu_select}, 0);
    exp_q.delete();
    rsp_ready = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("postrst_idle", {31'd0, busy}, 0);
    grant_log.delete();
    @(posedge clk); #1;
    fork
      send(0, 8'h01, 8'h03, 2'b00, 8'h01);
      send(1, 8'h01, 8'h03, 2'b01, 8'h03);
    join
    drain();
    check_log_alternates("postrst", 0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
